// File: rtl/id_ex_control_pkg.sv
// rtl/id_ex_control_pkg.sv - opcodes, ALUOp codes and control bundle for the ID/EX stage
package id_ex_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Shared with the EX-stage ALU control decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_control_main_decoder.sv
// rtl/id_ex_control_main_decoder.sv - combinational opcode to control decode
module main_decoder
    import id_ex_control_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       decode_illegal
);

    always_comb begin
        ctrl           = CTRL_NOP;
        decode_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
            end
            OP_BNE: begin
                ctrl.branch    = 1'b1;
                ctrl.branch_ne = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_ANDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_AND;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
                decode_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_control.sv
// rtl/id_ex_control.sv - main control decode and ID/EX control pipeline register
module id_ex_control
    import id_ex_control_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             hold,
    input  logic             clr_illegal,
    output logic             ex_reg_dst,
    output logic             ex_alu_src,
    output logic             ex_mem_to_reg,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_branch,
    output logic             ex_branch_ne,
    output logic             ex_jump,
    output logic [1:0]       ex_alu_op,
    output logic [5:0]       ex_funct,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic             ex_valid,
    output logic             illegal_op,
    output logic [CNT_W-1:0] bubble_cnt
);

    ctrl_t dec_ctrl;
    logic  decode_illegal;
    ctrl_t ex_ctrl;
    logic  load;
    logic  unused_rs;

    // rs is forwarded by the register file path, not through this register.
    assign unused_rs = ^id_instr[25:21];

    main_decoder u_main_decoder (
        .opcode         (id_instr[31:26]),
        .ctrl           (dec_ctrl),
        .decode_illegal (decode_illegal)
    );

    assign load = !flush && !hold && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl  <= CTRL_NOP;
            ex_valid <= 1'b0;
            ex_funct <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
        end else if (flush) begin
            ex_ctrl  <= CTRL_NOP;
            ex_valid <= 1'b0;
        end else if (hold) begin
            ex_ctrl  <= ex_ctrl;
        end else if (stall) begin
            ex_ctrl  <= CTRL_NOP;
            ex_valid <= 1'b0;
        end else begin
            // Illegal or empty slots still advance, but carry no side effects.
            ex_ctrl  <= (id_valid && !decode_illegal) ? dec_ctrl : CTRL_NOP;
            ex_valid <= id_valid;
            ex_funct <= id_instr[5:0];
            ex_rt    <= id_instr[20:16];
            ex_rd    <= id_instr[15:11];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op <= 1'b0;
        end else if (load && id_valid && decode_illegal) begin
            illegal_op <= 1'b1;
        end else if (clr_illegal) begin
            illegal_op <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (!flush && !hold && stall && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign ex_reg_dst    = ex_ctrl.reg_dst;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_branch_ne  = ex_ctrl.branch_ne;
    assign ex_jump       = ex_ctrl.jump;
    assign ex_alu_op     = ex_ctrl.alu_op;

endmodule
